// File: rtl/blit_wcombine_multi_if.sv
// Pixel-in / word-out bus of the blitter write combiner.
// The master side is the upstream colour stage together with the downstream FIFO ready.
interface blit_wcombine_multi_if #(
    parameter int ADDR_W = 26
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_address;
    logic [31:0]       in_wdata;
    logic [1:0]        in_bpp;
    logic              flush;
    logic              idle;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_address;
    logic [3:0]        out_wstrb;
    logic [31:0]       out_wdata;

    modport master (
        output in_valid, in_address, in_wdata, in_bpp, flush, out_ready,
        input  in_ready, idle, out_valid, out_address, out_wstrb, out_wdata
    );

    modport slave (
        input  in_valid, in_address, in_wdata, in_bpp, flush, out_ready,
        output in_ready, idle, out_valid, out_address, out_wstrb, out_wdata
    );
endinterface

// File: rtl/blit_wcombine_multi.sv
// Write-combining buffer: merges 8/16/32 bpp pixel writes into ENTRIES open word lines
// and emits them oldest-first as byte-strobed word writes.
module blit_wcombine_multi #(
    parameter int ADDR_W  = 26,
    parameter int ENTRIES = 2,
    parameter int TIMEOUT = 15
) (
    input logic                  clock,
    input logic                  reset,
    blit_wcombine_multi_if.slave bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam int TAG_W = ADDR_W - 2;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_d  [ENTRIES];
    logic [3:0]         strb_q [ENTRIES];
    logic [3:0]         strb_d [ENTRIES];
    logic [31:0]        data_q [ENTRIES];
    logic [31:0]        data_d [ENTRIES];
    logic [AGE_W-1:0]   age_q  [ENTRIES];
    logic [AGE_W-1:0]   age_d  [ENTRIES];
    logic [IDX_W-1:0]   rank_q [ENTRIES];
    logic [IDX_W-1:0]   rank_d [ENTRIES];

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_address_q, out_address_d;
    logic [3:0]        out_wstrb_q, out_wstrb_d;
    logic [31:0]       out_wdata_q, out_wdata_d;

    logic [1:0]         offset;
    logic [3:0]         base_strb, new_strb;
    logic [31:0]        new_data, new_mask;
    logic [TAG_W-1:0]   in_tag;
    logic [ENTRIES-1:0] raw_hit_vec, hit_vec;
    logic               hit, any_free, any_valid, forced, eligible, load_out, in_ready_c, accept;
    logic [IDX_W-1:0]   hit_idx, free_idx, oldest_idx;
    int                 valid_cnt;

    always_comb begin
        offset    = bus.in_address[1:0];
        base_strb = 4'b0001;
        case (bus.in_bpp)
            2'd1: begin
                offset    = {bus.in_address[1], 1'b0};
                base_strb = 4'b0011;
            end
            2'd2: begin
                offset    = 2'd0;
                base_strb = 4'b1111;
            end
            default: ;
        endcase
        new_strb = base_strb << offset;
        new_data = bus.in_wdata << {offset, 3'b000};
        for (int b = 0; b < 4; b++) begin
            new_mask[8*b +: 8] = {8{new_strb[b]}};
        end
        in_tag = bus.in_address[ADDR_W-1:2];
    end

    // Rank 0 marks the oldest valid line; ranks of valid lines stay contiguous.
    always_comb begin
        any_free    = 1'b0;
        any_valid   = 1'b0;
        free_idx    = '0;
        oldest_idx  = '0;
        valid_cnt   = 0;
        raw_hit_vec = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end else begin
                any_valid = 1'b1;
                valid_cnt = valid_cnt + 1;
                if (rank_q[i] == '0) begin
                    oldest_idx = IDX_W'(i);
                end
                raw_hit_vec[i] = (tag_q[i] == in_tag);
            end
        end
        forced   = bus.in_valid && !(|raw_hit_vec) && !any_free;
        eligible = any_valid && ((strb_q[oldest_idx] == 4'hF) || (age_q[oldest_idx] == AGE_MAX)
                                 || bus.flush || forced);
        load_out = eligible && (!out_valid_q || bus.out_ready);
        hit      = 1'b0;
        hit_idx  = '0;
        hit_vec  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            hit_vec[i] = raw_hit_vec[i] && !(load_out && (oldest_idx == IDX_W'(i)));
            if (hit_vec[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        in_ready_c = !reset && !bus.flush && (hit || any_free);
        accept     = bus.in_valid && in_ready_c;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        strb_d  = strb_q;
        data_d  = data_q;
        age_d   = age_q;
        rank_d  = rank_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + 1'b1;
            end
            if (load_out && valid_q[i]) begin
                if (oldest_idx == IDX_W'(i)) begin
                    valid_d[i] = 1'b0;
                end else begin
                    rank_d[i] = rank_q[i] - 1'b1;
                end
            end
        end
        if (accept && hit) begin
            strb_d[hit_idx] = strb_q[hit_idx] | new_strb;
            data_d[hit_idx] = (data_q[hit_idx] & ~new_mask) | (new_data & new_mask);
            age_d[hit_idx]  = '0;
        end else if (accept) begin
            valid_d[free_idx] = 1'b1;
            tag_d[free_idx]   = in_tag;
            strb_d[free_idx]  = new_strb;
            data_d[free_idx]  = new_data & new_mask;
            age_d[free_idx]   = '0;
            rank_d[free_idx]  = IDX_W'(valid_cnt - (load_out ? 1 : 0));
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_address_d = out_address_q;
        out_wstrb_d   = out_wstrb_q;
        out_wdata_d   = out_wdata_q;
        if (load_out) begin
            out_valid_d   = 1'b1;
            out_address_d = {tag_q[oldest_idx], 2'b00};
            out_wstrb_d   = strb_q[oldest_idx];
            out_wdata_d   = data_q[oldest_idx];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            out_valid_q   <= 1'b0;
            out_address_q <= '0;
            out_wstrb_q   <= '0;
            out_wdata_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                strb_q[i] <= '0;
                data_q[i] <= '0;
                age_q[i]  <= '0;
                rank_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            out_valid_q   <= out_valid_d;
            out_address_q <= out_address_d;
            out_wstrb_q   <= out_wstrb_d;
            out_wdata_q   <= out_wdata_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= tag_d[i];
                strb_q[i] <= strb_d[i];
                data_q[i] <= data_d[i];
                age_q[i]  <= age_d[i];
                rank_q[i] <= rank_d[i];
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_address = out_address_q;
    assign bus.out_wstrb   = out_wstrb_q;
    assign bus.out_wdata   = out_wdata_q;
    assign bus.idle        = !(|valid_q) && !out_valid_q && !bus.in_valid;
endmodule

// File: tb/tb_blit_wcombine_multi.sv
// Scenario bench for the write combiner: expected words are queued as pixels are
// driven and matched in order against each output handshake.
module tb_blit_wcombine_multi;
    localparam int ADDR_W  = 26;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        strb;
        logic [31:0]       data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    blit_wcombine_multi_if #(.ADDR_W(ADDR_W)) bus ();

    blit_wcombine_multi #(.ADDR_W(ADDR_W), .ENTRIES(2), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Every accepted output word must match the head of the expectation queue.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write got addr=%h strb=%b data=%h, required none",
                         bus.out_address, bus.out_wstrb, bus.out_wdata);
            end else begin
                e = sb_q.pop_front();
                if ({bus.out_address, bus.out_wstrb, bus.out_wdata} !== e) begin
                    failures++;
                    $display("[TB] FAIL scoreboard got addr=%h strb=%b data=%h, required addr=%h strb=%b data=%h",
                             bus.out_address, bus.out_wstrb, bus.out_wdata, e.addr, e.strb, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.strb = s;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic drive_pixel(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [1:0] bpp);
        int n;
        n = 0;
        bus.in_valid   = 1'b1;
        bus.in_address = a;
        bus.in_wdata   = d;
        bus.in_bpp     = bpp;
        @(negedge clock);
        while (!bus.in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            failures++;
            $display("[TB] FAIL accept_timeout addr=%h got in_ready=0, required 1", a);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout got pending=%0d, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_address = '0; bus.in_wdata = '0; bus.in_bpp = 2'd0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) tick();
        checks += 6;
        if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got %b, required 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b, required 0", bus.out_valid); end
        if (bus.out_address !== '0) begin failures++; $display("[TB] FAIL reset_out_address got %h, required 0", bus.out_address); end
        if (bus.out_wstrb !== 4'b0) begin failures++; $display("[TB] FAIL reset_out_wstrb got %b, required 0", bus.out_wstrb); end
        if (bus.out_wdata !== 32'b0) begin failures++; $display("[TB] FAIL reset_out_wdata got %h, required 0", bus.out_wdata); end
        if (bus.idle !== 1'b1) begin failures++; $display("[TB] FAIL reset_idle got %b, required 1", bus.idle); end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready got %b, required 1", bus.in_ready); end
    endtask

    task automatic test_full_word();
        int n;
        push_exp(26'h100, 4'b1111, 32'hAABBCCDD);
        drive_pixel(26'h100, 32'hAABBCCDD, 2'd2);
        wait_out_valid(n);
        checks++;
        if (n != 1) begin failures++; $display("[TB] FAIL full_word_latency got %0d edges, required 1", n); end
        wait_drain(20);
    endtask

    task automatic test_back_to_back();
        push_exp(26'h200, 4'b1111, 32'h44332211);
        drive_pixel(26'h200, 32'h11, 2'd0);
        drive_pixel(26'h201, 32'h22, 2'd0);
        drive_pixel(26'h202, 32'h33, 2'd0);
        drive_pixel(26'h203, 32'h44, 2'd0);
        wait_drain(20);
    endtask

    task automatic test_timeout();
        int n;
        push_exp(26'h304, 4'b1100, 32'hBEEF0000);
        drive_pixel(26'h306, 32'hBEEF, 2'd1);
        checks++;
        if (bus.idle !== 1'b0) begin failures++; $display("[TB] FAIL timeout_idle got %b, required 0", bus.idle); end
        wait_out_valid(n);
        checks++;
        if (n != TIMEOUT + 1) begin failures++; $display("[TB] FAIL timeout_latency got %0d edges, required %0d", n, TIMEOUT + 1); end
        wait_drain(20);
    endtask

    task automatic test_capacity();
        bus.out_ready = 1'b0;
        push_exp(26'h400, 4'b0001, 32'h11);
        push_exp(26'h500, 4'b0001, 32'h22);
        push_exp(26'h600, 4'b0001, 32'h33);
        drive_pixel(26'h400, 32'h11, 2'd0);
        drive_pixel(26'h500, 32'h22, 2'd0);
        bus.in_valid = 1'b1; bus.in_address = 26'h600; bus.in_wdata = 32'h33; bus.in_bpp = 2'd0;
        @(negedge clock);
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL capacity_stall got in_ready=%b, required 0", bus.in_ready); end
        tick();
        drive_pixel(26'h600, 32'h33, 2'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if ({bus.out_valid, bus.out_address, bus.out_wstrb, bus.out_wdata} !== {1'b1, 26'h400, 4'b0001, 32'h11}) begin
                failures++;
                $display("[TB] FAIL hold_stable got v=%b addr=%h strb=%b data=%h, required v=1 addr=400 strb=0001 data=00000011",
                         bus.out_valid, bus.out_address, bus.out_wstrb, bus.out_wdata);
            end
        end
        tick();
        bus.out_ready = 1'b1;
        wait_drain(100);
    endtask

    task automatic test_last_write_wins();
        push_exp(26'h700, 4'b0001, 32'h00000022);
        drive_pixel(26'h700, 32'h11, 2'd0);
        drive_pixel(26'h700, 32'h22, 2'd0);
        wait_drain(60);
    endtask

    task automatic test_flush();
        push_exp(26'h800, 4'b0001, 32'h0000005A);
        push_exp(26'h900, 4'b0011, 32'h00001234);
        drive_pixel(26'h800, 32'h5A, 2'd0);
        drive_pixel(26'h900, 32'h1234, 2'd1);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_address = 26'hA00; bus.in_wdata = 32'h77; bus.in_bpp = 2'd0;
        @(negedge clock);
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_in_ready got %b, required 0", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        wait_drain(20);
        tick();
        checks++;
        if (bus.idle !== 1'b1) begin failures++; $display("[TB] FAIL flush_idle got %b, required 1", bus.idle); end
        bus.flush = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        bus.out_ready = 1'b0;
        drive_pixel(26'hB00, 32'h01, 2'd0);
        drive_pixel(26'hC00, 32'h02, 2'd0);
        bus.flush = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL drain_loaded got out_valid=%b, required 1", bus.out_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_out_valid got %b, required 0", bus.out_valid); end
        sb_q.delete();
        bus.flush = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) tick();
        checks++;
        if ({bus.out_valid, bus.idle} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL post_reset_quiet got out_valid=%b idle=%b, required out_valid=0 idle=1", bus.out_valid, bus.idle);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        repeat (3) tick();
        test_back_to_back();
        repeat (3) tick();
        test_timeout();
        repeat (3) tick();
        test_capacity();
        repeat (3) tick();
        test_last_write_wins();
        repeat (3) tick();
        test_flush();
        repeat (3) tick();
        test_reset_mid_drain();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
